alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter TAG_W, default 4, width of the requester-supplied transaction tag.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid[1:0]  input  2  per-requester request valid; index 0 = port 0, index 1 = port 1.
REQ-005 req_ready[1:0]  output  2  per-requester request accepted this cycle.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  32 each  operands for port 0 and port 1.
REQ-007 req_sel0, req_sel1  input  4 each  ALU operation code (ADD 0000, SUB 1000, SLT 0111, SLTU 0110, SLL 0001, XOR 0010, SRL 0101, SRA 1101, OR 0011, AND 0100).
REQ-008 req_tag0, req_tag1  input  TAG_W each  tag echoed with the result.
REQ-009 rsp_valid[1:0]  output  2  per-requester result valid.
REQ-010 rsp_ready[1:0]  input  2  per-requester result consumed.
REQ-011 rsp_data0, rsp_data1  output  32 each  result for port 0 and port 1.
REQ-012 rsp_tag0, rsp_tag1  output  TAG_W each  echoed tag.
REQ-013 rsp_err[1:0]  output  2  result came from an undefined operation code.

Function
REQ-014 The block SHALL contain exactly one ALU datapath instance, shared by both ports.
REQ-015 At most one request SHALL be accepted per cycle; req_ready SHALL be one-hot or zero.
REQ-016 Port i is eligible when req_valid[i]=1 and its response slot is empty or drained this cycle (rsp_valid[i]=1 and rsp_ready[i]=1).
REQ-017 With one eligible port, that port SHALL be granted regardless of priority.
REQ-018 With two eligible ports, the port named by the 1-bit priority pointer SHALL be granted; after any grant the pointer SHALL point to the other port.
REQ-019 The pointer SHALL NOT change in a cycle with no grant.
REQ-020 req_ready SHALL depend combinationally on req_valid, rsp_valid, rsp_ready and pointer only, never on operands.
REQ-021 On grant of port i, the ALU result, tag and error flag SHALL be registered into slot i; rsp_valid[i] SHALL be 1 on the next cycle (latency 1).
REQ-022 Slot i SHALL hold data, tag and error stable while rsp_valid[i]=1 and rsp_ready[i]=0.
REQ-023 Simultaneous drain and new grant on slot i SHALL keep rsp_valid[i]=1 with the new contents.
REQ-024 Drain without grant SHALL clear rsp_valid[i] next cycle.
REQ-025 SLT SHALL compare signed, SLTU unsigned; shifts use B[4:0]; ADD/SUB wrap modulo 2^32.
REQ-026 An undefined code SHALL produce data 0 and rsp_err=1; defined codes produce rsp_err=0.
REQ-027 rsp_data/rsp_tag/rsp_err SHALL be don't-care when rsp_valid is 0, but SHALL be deterministic (reset value until first write).

Reset
REQ-028 Asserting rst SHALL immediately force rsp_valid=00, rsp_err=00, rsp_data0/1=0, rsp_tag0/1=0, pointer=port 0.
REQ-029 req_ready SHALL be 00 while rst is asserted.
REQ-030 A result held in a slot when rst asserts SHALL be discarded; no request is accepted until the first clk edge after rst deasserts.

Structure
REQ-031 Operation-code constants and the TAG_W default SHALL live in shared package alu_pkg, used by this block and the ALU datapath.
REQ-032 Grant logic SHALL be a separate sub-module rr_arbiter2 (inputs eligible[1:0], clk, rst; outputs grant[1:0]; owns the pointer).
REQ-033 Response slots SHALL be two identical registered depth-1 buffers; no FIFO deeper than 1.

Verification
REQ-034 Port 0 only: ADD A=5,B=7,tag=3, rsp_ready=1 -> next cycle rsp_valid0=1, data 12, tag 3, err 0.
REQ-035 Both valid every cycle, rsp_ready=11, after reset -> grants 0,1,0,1...; each port one result every 2 cycles.
REQ-036 Port 1 SLT A=0xFFFFFFFF,B=1 -> data 1; SLTU same operands -> data 0; SRA A=0x80000000,B=4 -> 0xF8000000.
REQ-037 Port 0 rsp_ready=0 holding result 12, new port 0 request -> req_ready0=0, data stays 12; port 1 still granted; raise rsp_ready0 -> port 0 accepted same cycle.
REQ-038 Sel=1111 -> data 0, rsp_err=1.
REQ-039 rst asserted mid-stream with both slots full -> rsp_valid=00 immediately, pointer=0; first post-reset contention grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, tag width default and arbitration pointer type.
// Used by the ALU datapath, the arbiter and the shared-ALU top.
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic {
    PRIO_P0 = 1'b0,
    PRIO_P1 = 1'b1
  } prio_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two-port request/response bundle for the shared ALU: master = requesters, slave = the block.
interface alu_share_arbiter_if #(
  parameter int TAG_W = alu_pkg::TAG_W_DEF
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [31:0]       req_a0;
  logic [31:0]       req_b0;
  logic [31:0]       req_a1;
  logic [31:0]       req_b1;
  logic [3:0]        req_sel0;
  logic [3:0]        req_sel1;
  logic [TAG_W-1:0]  req_tag0;
  logic [TAG_W-1:0]  req_tag1;

  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_data0;
  logic [31:0]       rsp_data1;
  logic [TAG_W-1:0]  rsp_tag0;
  logic [TAG_W-1:0]  rsp_tag1;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1,
           req_sel0, req_sel1, req_tag0, req_tag1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1,
           rsp_tag0, rsp_tag1, rsp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1,
           req_sel0, req_sel1, req_tag0, req_tag1, rsp_ready,
    output req_ready, rsp_valid, rsp_data0, rsp_data1,
           rsp_tag0, rsp_tag1, rsp_err
  );

endinterface

// File: rtl/alu_datapath.sv
// Purely combinational 32-bit ALU; undefined operation codes yield zero with err_o set.
module alu_datapath
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      sel_i,
  output logic [XLEN-1:0] y_o,
  output logic            err_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    y_o   = '0;
    err_o = 1'b0;
    case (sel_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {31'b0, a_i < b_i};
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = 32'($signed(a_i) >>> shamt);
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a 1-bit priority pointer that flips to the other port after any grant.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  prio_e ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (ptr_q == PRIO_P1) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = PRIO_P1;
    else if (grant[1]) ptr_d = PRIO_P0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment keeps every register sampling pre-edge values, avoiding race order.
    if (rst) ptr_q <= PRIO_P0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rsp_slot.sv
// Depth-1 registered response buffer: loads on grant, holds under backpressure, clears on drain.
module rsp_slot
  import alu_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [XLEN-1:0]  data_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  data_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  data_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;

  // A load wins over a same-cycle drain so back-to-back results stream without a bubble.
  always_comb begin
    valid_d = valid_q;
    if (load_i)       valid_d = 1'b1;
    else if (drain_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: payload is reset too, so outputs read as zero rather than X before the first load.
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q <= data_i;
        tag_q  <= tag_i;
        err_q  <= err_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;
  assign err_o   = err_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU; a round-robin arbiter picks one request per cycle into its response slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             pick_p1;
  logic [XLEN-1:0]  alu_a, alu_b, alu_y;
  logic [3:0]       alu_sel;
  logic             alu_err;
  logic [TAG_W-1:0] req_tag;

  // A port may be granted when its slot is empty or is being drained this very cycle.
  assign eligible = bus.req_valid & (~bus.rsp_valid | bus.rsp_ready);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .grant    (grant)
  );

  assign bus.req_ready = grant;

  assign pick_p1 = grant[1];
  assign alu_a   = pick_p1 ? bus.req_a1   : bus.req_a0;
  assign alu_b   = pick_p1 ? bus.req_b1   : bus.req_b0;
  assign alu_sel = pick_p1 ? bus.req_sel1 : bus.req_sel0;
  assign req_tag = pick_p1 ? bus.req_tag1 : bus.req_tag0;

  alu_datapath u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .sel_i (alu_sel),
    .y_o   (alu_y),
    .err_o (alu_err)
  );

  rsp_slot #(.TAG_W(TAG_W)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant[0]),
    .drain_i (bus.rsp_ready[0]),
    .data_i  (alu_y),
    .tag_i   (req_tag),
    .err_i   (alu_err),
    .valid_o (bus.rsp_valid[0]),
    .data_o  (bus.rsp_data0),
    .tag_o   (bus.rsp_tag0),
    .err_o   (bus.rsp_err[0])
  );

  rsp_slot #(.TAG_W(TAG_W)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant[1]),
    .drain_i (bus.rsp_ready[1]),
    .data_i  (alu_y),
    .tag_i   (req_tag),
    .err_i   (alu_err),
    .valid_o (bus.rsp_valid[1]),
    .data_o  (bus.rsp_data1),
    .tag_o   (bus.rsp_tag1),
    .err_o   (bus.rsp_err[1])
  );

endmodule
